// File: rtl/prbs_pkg.sv
// PRBS-31 (x^31 + x^28 + 1) constants and the multi-bit advance
// function shared by the generator and the checker side.
package prbs_pkg;

   localparam int unsigned PRBS31_TAP_A = 30;
   localparam int unsigned PRBS31_TAP_B = 27;
   localparam logic [30:0] PRBS31_SAFE_SEED = 31'h1;

   // Returns {next_state[30:0], bits[63:0]}; bits[0] is generated first.
   function automatic logic [94:0] prbs31_advance(
      input logic [30:0] state,
      input int unsigned nbits
   );
      logic [30:0] s;
      logic [63:0] bits;
      logic        nb;
      s    = state;
      bits = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < nbits) begin
            nb      = s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
            bits[i] = nb;
            s       = {s[29:0], nb};
         end
      end
      return {s, bits};
   endfunction

endpackage

// File: rtl/prbs_stream_gen.sv
// PRBS-31 AXI4-Stream word source with backpressure, deferred
// reseeding and single-word error injection.
module prbs_stream_gen
   import prbs_pkg::*;
#(
   parameter int unsigned TDATA_WIDTH  = 32,
   parameter logic [30:0] DEFAULT_SEED = 31'h1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [30:0]            seed,
   input  logic                   load_seed,
   input  logic                   inject_err,
   output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                   M_AXIS_TVALID,
   input  logic                   M_AXIS_TREADY,
   output logic [31:0]            word_count,
   output logic                   inject_pending
);

   logic [30:0]            lfsr_q, lfsr_d;
   logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic [31:0]            count_q, count_d;
   logic                   inj_q, inj_d;
   logic                   spend_q, spend_d;
   logic [30:0]            sval_q, sval_d;

   logic [30:0] seed_fix;
   logic [30:0] base;
   logic [94:0] adv;
   logic        hand;
   logic        load;
   logic        unused_adv;

   always_comb begin
      lfsr_d   = lfsr_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      count_d  = count_q;
      inj_d    = inj_q | inject_err;
      spend_d  = spend_q;
      sval_d   = sval_q;
      load     = 1'b0;
      seed_fix = (seed == 31'd0) ? PRBS31_SAFE_SEED : seed;
      hand     = tvalid_q & M_AXIS_TREADY;

      // A reseed while a word is held replaces the advanced state at the hand
      base = lfsr_q;
      if (tvalid_q & load_seed)
         base = seed_fix;
      else if (tvalid_q & spend_q)
         base = sval_q;

      adv        = prbs31_advance(base, TDATA_WIDTH);
      unused_adv = ^adv;

      if (hand) begin
         count_d = count_q + 32'd1;
         spend_d = 1'b0;
         if (enable) begin
            load = 1'b1;
         end else begin
            tvalid_d = 1'b0;
            lfsr_d   = base;
         end
      end else if (tvalid_q) begin
         if (load_seed) begin
            spend_d = 1'b1;
            sval_d  = seed_fix;
         end
      end else if (load_seed) begin
         lfsr_d = seed_fix;
      end else if (enable) begin
         load = 1'b1;
      end

      if (load) begin
         tvalid_d   = 1'b1;
         tdata_d    = adv[TDATA_WIDTH-1:0];
         tdata_d[0] = adv[0] ^ inj_q;
         lfsr_d     = adv[94:64];
         if (inj_q)
            inj_d = inject_err;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q   <= DEFAULT_SEED;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         count_q  <= '0;
         inj_q    <= 1'b0;
         spend_q  <= 1'b0;
         sval_q   <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         count_q  <= count_d;
         inj_q    <= inj_d;
         spend_q  <= spend_d;
         sval_q   <= sval_d;
      end
   end

   assign M_AXIS_TDATA   = tdata_q;
   assign M_AXIS_TVALID  = tvalid_q;
   assign word_count     = count_q;
   assign inject_pending = inj_q;

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Directed bench for prbs_stream_gen with an independent serial
// PRBS-31 reference model.
module tb_prbs_stream_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [30:0] seed;
   logic        load_seed;
   logic        inject_err;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic [31:0] word_count;
   logic        inject_pending;

   int n_checks = 0;
   int n_errors = 0;

   logic [30:0] m_lfsr;
   logic [31:0] w;
   logic [31:0] cnt;

   always #5 clk = ~clk;

   prbs_stream_gen #(
      .TDATA_WIDTH (32),
      .DEFAULT_SEED(31'h1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .seed          (seed),
      .load_seed     (load_seed),
      .inject_err    (inject_err),
      .M_AXIS_TDATA  (tdata),
      .M_AXIS_TVALID (tvalid),
      .M_AXIS_TREADY (tready),
      .word_count    (word_count),
      .inject_pending(inject_pending)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_word(output logic [31:0] wd);
      logic nb;
      wd = '0;
      for (int i = 0; i < 32; i++) begin
         nb     = m_lfsr[30] ^ m_lfsr[27];
         wd[i]  = nb;
         m_lfsr = {m_lfsr[29:0], nb};
      end
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      seed       = '0;
      load_seed  = 1'b0;
      inject_err = 1'b0;
      tready     = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_count", word_count, 0);
      check("rst_pend", inject_pending, 0);

      // Stream from default seed, one word per clock
      enable = 1'b1;
      m_lfsr = 31'h1;
      cnt    = 0;
      @(negedge clk);
      next_word(w);
      check("first_tvalid", tvalid, 1);
      check("first_tdata", tdata, 32'h4800_0000);
      check("first_count", word_count, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cnt++;
         next_word(w);
         check("b2b_tdata", tdata, w);
         check("b2b_count", word_count, cnt);
         check("b2b_tvalid", tvalid, 1);
      end

      // Backpressure for 5 clocks
      tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_tdata", tdata, w);
         check("bp_tvalid", tvalid, 1);
         check("bp_count", word_count, cnt);
      end
      tready = 1'b1;
      @(negedge clk);
      cnt++;
      next_word(w);
      check("bp_resume", tdata, w);
      check("bp_rcount", word_count, cnt);

      // Three injection pulses while held: one corrupted word only
      tready     = 1'b0;
      inject_err = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("inj_held", tdata, w);
         check("inj_pend", inject_pending, 1);
      end
      inject_err = 1'b0;
      tready     = 1'b1;
      @(negedge clk);
      cnt++;
      next_word(w);
      check("inj_word", tdata, w ^ 32'h1);
      check("inj_clear", inject_pending, 0);
      @(negedge clk);
      cnt++;
      next_word(w);
      check("inj_clean", tdata, w);
      check("inj_count", word_count, cnt);

      // Zero seed while a word is held
      tready    = 1'b0;
      seed      = 31'd0;
      load_seed = 1'b1;
      @(negedge clk);
      load_seed = 1'b0;
      check("seed_held1", tdata, w);
      @(negedge clk);
      check("seed_held2", tdata, w);
      tready = 1'b1;
      @(negedge clk);
      cnt++;
      m_lfsr = 31'h1;
      next_word(w);
      check("seed_zero", tdata, 32'h4800_0000);
      check("seed_model", tdata, w);
      @(negedge clk);
      cnt++;
      next_word(w);
      check("seed_next", tdata, w);

      // Drop enable while held: word stays until its hand
      tready = 1'b0;
      enable = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("en_tvalid", tvalid, 1);
         check("en_tdata", tdata, w);
      end
      tready = 1'b1;
      @(negedge clk);
      cnt++;
      check("en_drop", tvalid, 0);
      check("en_count", word_count, cnt);

      // Reseed and enable together while idle: seed wins
      seed      = 31'h123_4567;
      load_seed = 1'b1;
      enable    = 1'b1;
      @(negedge clk);
      load_seed = 1'b0;
      check("idle_seed_tv", tvalid, 0);
      @(negedge clk);
      m_lfsr = 31'h123_4567;
      next_word(w);
      check("idle_seed_tv1", tvalid, 1);
      check("idle_seed_w", tdata, w);

      // Asynchronous reset mid-stream, then restart
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_tvalid", tvalid, 0);
      check("arst_count", word_count, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      m_lfsr = 31'h1;
      next_word(w);
      check("rs_first", tdata, 32'h4800_0000);
      check("rs_tvalid", tvalid, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         next_word(w);
         check("rs_tdata", tdata, w);
         check("rs_count", word_count, i + 1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
